// File: rtl/mult_pkg.sv
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared definitions for the shared-multiplier arbiter: arbiter
//            state encodings, default parameter values and a product-width
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 63;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_ISSUE     = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_RESP      = 3'd4
  } arb_state_t;

  // Product of two w-bit operands.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set
//            request bit at or after ptr, searching cyclically.
// Ports    : req   in  N_REQ   request levels
//            ptr   in  IDX_W   highest-priority index
//            gnt   out N_REQ   one-hot winner (zero when no request)
//            idx   out IDX_W   winner index
//            valid out 1       any request present
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int               k;
    logic [IDX_W-1:0] k_idx;
    k     = 0;
    k_idx = '0;
    gnt   = '0;
    idx   = '0;
    valid = |req;
    // Walk offsets from farthest to nearest so the closest request to ptr
    // is the last one written and therefore wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      k_idx = IDX_W'(k);
      if (req[k_idx]) idx = k_idx;
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin scheduler sharing one start/done multiplier among
//            N_REQ requesters. Grants a requester, latches its operands,
//            pulses start, waits for the multiplier to go busy and return
//            idle, then hands the product back with a one-cycle ack and
//            rotates priority past the served requester. A watchdog aborts a
//            stuck job, raises a sticky error and still acks the client.
// Ports    : i_CLK, i_RESET (async active-low)
//            i_REQ/i_A/i_B       requester side (operands packed per index)
//            o_GNT/o_ACK         one-hot grant and result strobe
//            o_PRODUCT, o_ERR    result and sticky timeout flag
//            o_MUL_A/B/START     multiplier operands and start
//            i_MUL_DONE/PRODUCT  multiplier status and result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        i_CLK,
  input  logic                        i_RESET,
  input  logic [N_REQ-1:0]            i_REQ,
  input  logic [N_REQ*WIDTH-1:0]      i_A,
  input  logic [N_REQ*WIDTH-1:0]      i_B,
  output logic [N_REQ-1:0]            o_GNT,
  output logic [N_REQ-1:0]            o_ACK,
  output logic [prod_width(WIDTH)-1:0] o_PRODUCT,
  output logic                        o_ERR,
  output logic [WIDTH-1:0]            o_MUL_A,
  output logic [WIDTH-1:0]            o_MUL_B,
  output logic                        o_MUL_START,
  input  logic                        i_MUL_DONE,
  input  logic [prod_width(WIDTH)-1:0] i_MUL_PRODUCT
);

  localparam int PW    = prod_width(WIDTH);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] gnt_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [PW-1:0]    product;
  logic             err;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             timed_out;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (i_REQ),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign timed_out = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state   <= ARB_IDLE;
      idx     <= '0;
      ptr     <= '0;
      gnt_q   <= '0;
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      product <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          // Only launch when the multiplier reports idle, so start never
          // lands on a busy unit.
          if (pick_valid && i_MUL_DONE) begin
            gnt_q <= pick_gnt;
            idx   <= pick_idx;
            mul_a <= i_A[pick_idx*WIDTH +: WIDTH];
            mul_b <= i_B[pick_idx*WIDTH +: WIDTH];
            state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          cnt   <= '0;
          state <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          // done is high while idle, so completion is only meaningful after
          // it has been seen low at least once.
          if (!i_MUL_DONE) begin
            state <= ARB_WAIT_DONE;
            if (!timed_out) cnt <= cnt + 1'b1;
          end else if (timed_out) begin
            err     <= 1'b1;
            product <= '0;
            state   <= ARB_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_WAIT_DONE: begin
          if (i_MUL_DONE) begin
            product <= i_MUL_PRODUCT;
            state   <= ARB_RESP;
          end else if (timed_out) begin
            err     <= 1'b1;
            product <= '0;
            state   <= ARB_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_RESP: begin
          if (idx == IDX_W'(N_REQ - 1)) ptr <= '0;
          else                          ptr <= idx + 1'b1;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Decoded from registers only, so these are glitch-free and drop to zero
  // immediately on reset.
  assign o_GNT       = (state != ARB_IDLE) ? gnt_q : '0;
  assign o_ACK       = (state == ARB_RESP) ? gnt_q : '0;
  assign o_MUL_START = (state == ARB_ISSUE);
  assign o_MUL_A     = mul_a;
  assign o_MUL_B     = mul_b;
  assign o_PRODUCT   = product;
  assign o_ERR       = err;

endmodule

`default_nettype wire
